// File: rtl/uart_tx_driver_pkg.sv
// ============================================================
// Module : uart_tx_driver_pkg
// Brief  : Shared UART TX register map, status bits and FSM states.
// Rev    : 1.0
// ============================================================
`default_nettype none

package uart_tx_driver_pkg;

  localparam logic [1:0] UART_DATA = 2'b00;
  localparam logic [1:0] UART_CTRL = 2'b01;

  localparam int STATUS_FULL     = 0;
  localparam int STATUS_BUSY     = 1;
  localparam int STATUS_OVERFLOW = 2;
  localparam int STATUS_EMPTY    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================
// Module : uart_tx_fifo
// Brief  : Circular byte FIFO; a pop frees a slot for a same-cycle push.
// Rev    : 1.0
// ============================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     iCpuClock,
  input  logic                     iCpuReset,
  input  logic                     iPush,
  input  logic [7:0]               iPushData,
  input  logic                     iPop,
  output logic [7:0]               oHeadData,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int                c_ptrWidth = $clog2(DEPTH);
  localparam logic [c_ptrWidth:0] c_depthCount = (c_ptrWidth + 1)'(DEPTH);

  logic [7:0]            r_mem [DEPTH];
  logic [c_ptrWidth-1:0] r_wrPtr;
  logic [c_ptrWidth-1:0] r_rdPtr;
  logic [c_ptrWidth:0]   r_count;
  logic                  w_doPop;
  logic                  w_doPush;

  assign oFull     = (r_count == c_depthCount);
  assign oEmpty    = (r_count == '0);
  assign oCount    = r_count;
  assign oHeadData = r_mem[r_rdPtr];

  assign w_doPop  = iPop && !oEmpty;
  assign w_doPush = iPush && (!oFull || w_doPop);

  always_ff @(posedge iCpuClock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= iPushData;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + 1'b1;
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_driver.sv
// ============================================================
// Module : uart_tx_driver
// Brief  : CPU-facing 8N1 UART transmitter with TX FIFO and status word.
// Rev    : 1.0
// ============================================================
`default_nettype none

module uart_tx_driver
  import uart_tx_driver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        iCpuClock,
  input  logic        iCpuReset,
  input  logic        iDoUartWrite,
  input  logic [1:0]  iUartAddress,
  input  logic [15:0] iUartDataToWrite,
  input  logic        iDoUartStatusRead,
  output logic [15:0] oUartStatusRead,
  output logic        oUartTx
);

  localparam int                 c_cntWidth  = $clog2(CLKS_PER_BIT);
  localparam logic [c_cntWidth-1:0] c_lastCount = c_cntWidth'(CLKS_PER_BIT - 1);

  txState_t                  r_state;
  txState_t                  w_nextState;
  logic [c_cntWidth-1:0]     r_baudCnt;
  logic [2:0]                r_bitIdx;
  logic [7:0]                r_shift;
  logic                      r_tx;
  logic                      r_overflow;
  logic [15:0]               r_status;

  logic                      w_push;
  logic                      w_clearOverflow;
  logic                      w_pop;
  logic                      w_txNext;
  logic                      w_bitDone;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_busy;
  logic [7:0]                w_headData;
  logic [15:0]               w_statusWord;
  logic [$clog2(FIFO_DEPTH):0] w_unusedCount;
  logic                      w_unusedHighBits;

  assign w_push           = iDoUartWrite && (iUartAddress == UART_DATA);
  assign w_clearOverflow  = iDoUartWrite && (iUartAddress == UART_CTRL);
  assign w_unusedHighBits = ^iUartDataToWrite[15:8];
  assign w_bitDone        = (r_state != IDLE) && (r_baudCnt == c_lastCount);
  assign w_busy           = (r_state != IDLE) || !w_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCpuClock (iCpuClock),
    .iCpuReset (iCpuReset),
    .iPush     (w_push),
    .iPushData (iUartDataToWrite[7:0]),
    .iPop      (w_pop),
    .oHeadData (w_headData),
    .oFull     (w_full),
    .oEmpty    (w_empty),
    .oCount    (w_unusedCount)
  );

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_nextState = START;
      START:   if (w_bitDone) w_nextState = DATA;
      DATA:    if (w_bitDone && (r_bitIdx == 3'd7)) w_nextState = STOP;
      STOP:    if (w_bitDone) w_nextState = w_empty ? IDLE : START;
      default: w_nextState = IDLE;
    endcase
  end

  // STOP chains straight into the next START when a byte is waiting.
  always_comb begin
    w_pop    = 1'b0;
    w_txNext = r_tx;
    unique case (r_state)
      IDLE: begin
        w_txNext = 1'b1;
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_txNext = 1'b0;
        end
      end
      START: if (w_bitDone) w_txNext = r_shift[0];
      DATA:  if (w_bitDone) w_txNext = (r_bitIdx == 3'd7) ? 1'b1 : r_shift[1];
      STOP: begin
        if (w_bitDone) begin
          w_pop    = !w_empty;
          w_txNext = w_empty;
        end
      end
      default: w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      r_tx      <= 1'b1;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
    end else begin
      r_tx <= w_txNext;
      if ((r_state == IDLE) || w_bitDone) begin
        r_baudCnt <= '0;
      end else begin
        r_baudCnt <= r_baudCnt + 1'b1;
      end
      if (w_pop) begin
        r_shift <= w_headData;
      end else if ((r_state == DATA) && w_bitDone) begin
        r_shift  <= {1'b0, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 1'b1;
      end
    end
  end

  always_comb begin
    w_statusWord                  = '0;
    w_statusWord[STATUS_FULL]     = w_full;
    w_statusWord[STATUS_BUSY]     = w_busy;
    w_statusWord[STATUS_OVERFLOW] = r_overflow;
    w_statusWord[STATUS_EMPTY]    = w_empty;
  end

  // A dropped push outranks a same-cycle clear.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      r_overflow <= 1'b0;
      r_status   <= '0;
    end else begin
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_clearOverflow) begin
        r_overflow <= 1'b0;
      end
      if (iDoUartStatusRead) begin
        r_status <= (iUartAddress == UART_DATA) ? w_statusWord : '0;
      end
    end
  end

  assign oUartTx         = r_tx;
  assign oUartStatusRead = r_status;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_driver.sv
// ============================================================
// Module : tb_uart_tx_driver
// Brief  : Randomised bench against a frame-schedule model of the transmitter.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_uart_tx_driver;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk     = 1'b0;
  logic        rstN    = 1'b1;
  logic        doWrite = 1'b0;
  logic        doRead  = 1'b0;
  logic [1:0]  addr    = 2'b00;
  logic [15:0] wdata   = 16'h0000;
  logic [15:0] status;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_driver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .iCpuClock         (clk),
    .iCpuReset         (rstN),
    .iDoUartWrite      (doWrite),
    .iUartAddress      (addr),
    .iUartDataToWrite  (wdata),
    .iDoUartStatusRead (doRead),
    .oUartStatusRead   (status),
    .oUartTx           (tx)
  );

  int nChecks = 0;
  int nPassed = 0;
  int edgeNum = 0;

  // Every accepted byte: value, write edge, and the edge its start bit begins.
  logic [7:0] qByte[$];
  int         qWr[$];
  int         qStart[$];
  logic       modelOvf   = 1'b0;
  logic [15:0] heldStatus = 16'h0000;

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edgeNum);
  endtask

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int lastEnd();
    return (qStart.size() == 0) ? 0 : qStart[qStart.size() - 1] + FRAME;
  endfunction

  function automatic int occAt(input int n);
    int c = 0;
    foreach (qStart[i]) if (qWr[i] < n && qStart[i] >= n) c++;
    return c;
  endfunction

  function automatic logic popAt(input int n);
    foreach (qStart[i]) if (qStart[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic activeAt(input int t);
    foreach (qStart[i]) if (t >= qStart[i] && t < qStart[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // Line level after edge t: start bit, eight data bits LSB first, stop bit.
  function automatic logic expTx(input int t);
    int k;
    foreach (qStart[i]) begin
      if (t >= qStart[i] && t < qStart[i] + FRAME) begin
        k = (t - qStart[i]) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return qByte[i][k - 1];
      end
    end
    return 1'b1;
  endfunction

  task automatic clearModel();
    qByte.delete();
    qWr.delete();
    qStart.delete();
    modelOvf   = 1'b0;
    heldStatus = 16'h0000;
  endtask

  task automatic step(input logic wr, input logic [1:0] a, input logic [15:0] d, input logic rd);
    int   occ;
    logic pop;
    doWrite = wr;
    addr    = a;
    wdata   = d;
    doRead  = rd;
    @(posedge clk);
    edgeNum++;
    if (!rstN) begin
      clearModel();
    end else begin
      occ = occAt(edgeNum);
      pop = popAt(edgeNum);
      if (rd) begin
        heldStatus = 16'h0000;
        if (a == 2'b00) begin
          heldStatus[0] = (occ == DEPTH);
          heldStatus[1] = (occ > 0) || activeAt(edgeNum - 1);
          heldStatus[2] = modelOvf;
          heldStatus[3] = (occ == 0);
        end
      end
      if (wr && a == 2'b00) begin
        if (occ < DEPTH || pop) begin
          qByte.push_back(d[7:0]);
          qWr.push_back(edgeNum);
          qStart.push_back(maxInt(edgeNum + 1, lastEnd()));
        end else begin
          modelOvf = 1'b1;
        end
      end else if (wr && a == 2'b01) begin
        modelOvf = 1'b0;
      end
    end
    #1;
    checkValue("tx", {15'b0, tx}, {15'b0, expTx(edgeNum)});
    checkValue(rd ? "status_read" : "status_hold", status, heldStatus);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 16'h0000, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 * FRAME && lastEnd() > edgeNum; i++) step(1'b0, 2'b00, 16'h0000, 1'b0);
    idle(3);
  endtask

  initial begin
    int s0;
    int idx;
    #1 rstN = 1'b0;
    clearModel();
    #1;
    checkValue("reset_tx", {15'b0, tx}, 16'h0001);
    checkValue("reset_status", status, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 16'h0000, 1'b1);
    rstN = 1'b1;
    idle(2);

    // Single frame; upper data bits must be ignored.
    step(1'b1, 2'b00, 16'h1255, 1'b0);
    drain();
    step(1'b0, 2'b00, 16'h0000, 1'b1);
    checkValue("status_after_frame", status, 16'h0008);

    // Back-to-back frames.
    step(1'b1, 2'b00, 16'h00A5, 1'b0);
    step(1'b1, 2'b00, 16'h003C, 1'b0);
    drain();

    // Six writes while idle: one in flight, four queued, one dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 16'($urandom), 1'b0);
    step(1'b0, 2'b00, 16'h0000, 1'b1);
    checkValue("ovf_full_bits", status & 16'h0005, 16'h0005);
    drain();
    step(1'b1, 2'b01, 16'h0000, 1'b0);
    step(1'b0, 2'b00, 16'h0000, 1'b1);
    checkValue("ovf_cleared", status, 16'h0008);

    // Full FIFO with a push landing exactly on the stop-bit end.
    idx = qStart.size();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 16'($urandom), 1'b0);
    s0 = qStart[idx];
    while (edgeNum + 1 < s0 + FRAME) step(1'b0, 2'b00, 16'h0000, 1'b0);
    step(1'b1, 2'b00, 16'h00C3, 1'b0);
    step(1'b0, 2'b00, 16'h0000, 1'b1);
    checkValue("no_ovf_on_swap", status & 16'h0004, 16'h0000);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 2),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           16'($urandom),
           ($urandom_range(0, 5) == 0));
    end
    drain();

    // Asynchronous reset in the middle of the data bits.
    idx = qStart.size();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 16'($urandom), 1'b0);
    s0 = qStart[idx];
    while (edgeNum < s0 + 5 * CPB + 1) step(1'b0, 2'b00, 16'h0000, 1'b0);
    #2 rstN = 1'b0;
    clearModel();
    #1;
    checkValue("async_rst_tx", {15'b0, tx}, 16'h0001);
    checkValue("async_rst_status", status, 16'h0000);
    idle(3);
    rstN = 1'b1;
    idle(100);
    step(1'b0, 2'b00, 16'h0000, 1'b1);
    checkValue("status_after_rst", status, 16'h0008);

    // Unmapped addresses.
    step(1'b1, 2'b10, 16'h00FF, 1'b0);
    step(1'b1, 2'b11, 16'h0000, 1'b0);
    idle(8);
    step(1'b0, 2'b11, 16'h0000, 1'b1);
    checkValue("read_addr11", status, 16'h0000);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
